// File: rtl/pwr_mon_pkg.sv
// Shared types and defaults for the switching-activity monitor.
// Holds read FSM states, default sizes and the default counter max.
package pwr_mon_pkg;

    localparam int NCH_DEF = 8;
    localparam int CW_DEF  = 16;
    localparam int IW_DEF  = 3;

    localparam logic [CW_DEF-1:0] CNT_MAX = {CW_DEF{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACK  = 2'd1,
        WAIT = 2'd2
    } rd_state_e;

endpackage

// File: rtl/pwr_edge_counter.sv
// One monitored channel: level register, rise detect, counter, overflow.
// Ports: clk, rst_n, ev (level), clr (sync clear),
//        cnt_nxt (post-update count), ovf (sticky overflow).
// PWR_CNT_SAT_EN: saturate at max instead of wrapping.
module pwr_edge_counter #(
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ev,
    input  logic          clr,
    output logic [CW-1:0] cnt_nxt,
    output logic          ovf
);

    localparam logic [CW-1:0] MAX = {CW{1'b1}};

    logic          ev_q;
    logic          rise;
    logic          ovf_nxt;
    logic [CW-1:0] cnt;

    assign rise = ev & ~ev_q;

    // cnt_nxt is also the value a same-edge read captures.
    always_comb begin
        cnt_nxt = cnt;
        ovf_nxt = ovf;
        if (clr) begin
            cnt_nxt = '0;
            ovf_nxt = 1'b0;
        end else if (rise) begin
            if (cnt == MAX) begin
                ovf_nxt = 1'b1;
`ifdef PWR_CNT_SAT_EN
                cnt_nxt = MAX;
`else
                cnt_nxt = '0;
`endif
            end else begin
                cnt_nxt = cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev_q <= 1'b0;
            cnt  <= '0;
            ovf  <= 1'b0;
        end else begin
            ev_q <= ev;
            cnt  <= cnt_nxt;
            ovf  <= ovf_nxt;
        end
    end

endmodule

// File: rtl/pwr_activity_counter.sv
// Per-channel rising-transition counters with a four-phase read port.
// Ports: C, RN (async low), EV[NCH], CLR, RD_REQ, RD_IDX[IW]
//        -> RD_ACK, RD_DATA[CW], RD_ERR, OVF[NCH].
// PWR_CNT_SAT_EN: counters saturate instead of wrapping.
module pwr_activity_counter
    import pwr_mon_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = CW_DEF,
    parameter int IW  = IW_DEF
) (
    input  logic           C,
    input  logic           RN,
    input  logic [NCH-1:0] EV,
    input  logic           CLR,
    input  logic           RD_REQ,
    input  logic [IW-1:0]  RD_IDX,
    output logic           RD_ACK,
    output logic [CW-1:0]  RD_DATA,
    output logic           RD_ERR,
    output logic [NCH-1:0] OVF
);

    logic [CW-1:0] cnt_nxt [NCH];
    logic [CW-1:0] sel_data;
    logic          sel_err;
    rd_state_e     state;

    for (genvar i = 0; i < NCH; i++) begin : g_ch
        pwr_edge_counter #(
            .CW(CW)
        ) u_ch (
            .clk    (C),
            .rst_n  (RN),
            .ev     (EV[i]),
            .clr    (CLR),
            .cnt_nxt(cnt_nxt[i]),
            .ovf    (OVF[i])
        );
    end

    // Compare-based mux keeps out-of-range indices from
    // reaching the array and yields zero for them.
    always_comb begin
        sel_data = '0;
        sel_err  = (int'(RD_IDX) >= NCH);
        for (int i = 0; i < NCH; i++) begin
            if (RD_IDX == IW'(i)) begin
                sel_data = cnt_nxt[i];
            end
        end
    end

    always_ff @(posedge C or negedge RN) begin
        if (!RN) begin
            state   <= IDLE;
            RD_ACK  <= 1'b0;
            RD_DATA <= '0;
            RD_ERR  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    RD_ACK <= 1'b0;
                    if (RD_REQ) begin
                        RD_DATA <= sel_data;
                        RD_ERR  <= sel_err;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    RD_ACK <= 1'b1;
                    state  <= RD_REQ ? WAIT : IDLE;
                end
                WAIT: begin
                    if (!RD_REQ) begin
                        RD_ACK <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    RD_ACK <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pwr_activity_counter.sv
// Bench for pwr_activity_counter with NCH=6, CW=4, IW=3.
// Table vectors, hand sequences and a random run against a model.
module tb_pwr_activity_counter;

    localparam int NCH = 6;
    localparam int CW  = 4;
    localparam int IW  = 3;
    localparam int MAX = (1 << CW) - 1;
`ifdef PWR_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic           C;
    logic           RN;
    logic [NCH-1:0] EV;
    logic           CLR;
    logic           RD_REQ;
    logic [IW-1:0]  RD_IDX;
    logic           RD_ACK;
    logic [CW-1:0]  RD_DATA;
    logic           RD_ERR;
    logic [NCH-1:0] OVF;

    pwr_activity_counter #(
        .NCH(NCH),
        .CW (CW),
        .IW (IW)
    ) dut (
        .C      (C),
        .RN     (RN),
        .EV     (EV),
        .CLR    (CLR),
        .RD_REQ (RD_REQ),
        .RD_IDX (RD_IDX),
        .RD_ACK (RD_ACK),
        .RD_DATA(RD_DATA),
        .RD_ERR (RD_ERR),
        .OVF    (OVF)
    );

    initial begin
        C = 1'b0;
        forever #5 C = ~C;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: sim time limit reached");
        $fatal(1, "watchdog");
    end

    int n_checks = 0;
    int n_errors = 0;

    int             m_cnt  [NCH];
    logic [NCH-1:0] m_ovf;
    logic [NCH-1:0] m_prev;
    bit             rand_ev = 1'b0;

    typedef struct {
        int             ch;
        int             n_rise;
        int             idx;
        int             hold;
        int             exp_data;
        int             exp_err;
        logic [NCH-1:0] exp_ovf;
    } vec_t;

    vec_t vecs [7];

    task automatic check(input string name,
                         input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h",
                     name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) m_cnt[i] = 0;
        m_ovf  = '0;
        m_prev = '0;
    endtask

    // Counts rises from the sampled levels; wrap or clamp by config.
    task automatic model_step();
        bit r;
        for (int i = 0; i < NCH; i++) begin
            r = EV[i] && !m_prev[i];
            m_prev[i] = EV[i];
            if (CLR) begin
                m_cnt[i] = 0;
                m_ovf[i] = 1'b0;
            end else if (r) begin
                if (m_cnt[i] == MAX) m_ovf[i] = 1'b1;
                if (SAT)
                    m_cnt[i] = (m_cnt[i] + 1 > MAX) ? MAX : m_cnt[i] + 1;
                else
                    m_cnt[i] = (m_cnt[i] + 1) % (MAX + 1);
            end
        end
    endtask

    task automatic tick();
        if (rand_ev) begin
            EV  = NCH'($urandom);
            CLR = ($urandom_range(0, 24) == 0);
        end
        @(posedge C);
        if (!RN) model_reset();
        else model_step();
        #1;
        check("ovf", 64'(OVF), 64'(m_ovf));
    endtask

    task automatic pulse(input int ch);
        EV[ch] = 1'b1;
        tick();
        EV[ch] = 1'b0;
        tick();
    endtask

    task automatic do_read(input int idx, input int hold,
                           output int data, output int err);
        int e_data;
        int e_err;
        RD_REQ = 1'b1;
        RD_IDX = IW'(idx);
        tick();
        e_err  = (idx >= NCH) ? 1 : 0;
        e_data = e_err ? 0 : m_cnt[idx];
        check("ack_early", 64'(RD_ACK), 64'd0);
        tick();
        check("ack_rise", 64'(RD_ACK), 64'd1);
        check("rd_data", 64'(RD_DATA), 64'(e_data));
        check("rd_err", 64'(RD_ERR), 64'(e_err));
        data = int'(RD_DATA);
        err  = int'(RD_ERR);
        for (int h = 0; h < hold; h++) begin
            tick();
            check("ack_hold", 64'(RD_ACK), 64'd1);
            check("data_hold", 64'(RD_DATA), 64'(e_data));
        end
        RD_REQ = 1'b0;
        tick();
        check("ack_drop", 64'(RD_ACK), 64'd0);
        check("data_keep", 64'(RD_DATA), 64'(e_data));
    endtask

    initial begin
        int d;
        int e;

        vecs[0] = '{2,  5, 2, 0, 5, 0, 6'b000000};
        vecs[1] = '{0,  3, 0, 0, 3, 0, 6'b000000};
        vecs[2] = '{5, 15, 5, 1, 15, 0, 6'b000000};
        vecs[3] = '{1,  0, 1, 0, 0, 0, 6'b000000};
        vecs[4] = '{3, 17, 3, 0, SAT ? 15 : 1, 0, 6'b001000};
        vecs[5] = '{4,  2, 7, 2, 0, 1, 6'b000000};
        vecs[6] = '{4,  2, 6, 0, 0, 1, 6'b000000};

        RN     = 1'b0;
        EV     = 6'b000001;
        CLR    = 1'b0;
        RD_REQ = 1'b0;
        RD_IDX = '0;
        model_reset();
        tick();
        tick();
        check("rst_ack", 64'(RD_ACK), 64'd0);
        check("rst_data", 64'(RD_DATA), 64'd0);
        check("rst_err", 64'(RD_ERR), 64'd0);
        check("rst_ovf", 64'(OVF), 64'd0);

        // Level held high through reset release counts once.
        RN = 1'b1;
        repeat (3) tick();
        do_read(0, 0, d, e);
        check("hold_through_rst", 64'(d), 64'd1);
        EV = '0;
        tick();

        foreach (vecs[v]) begin
            CLR = 1'b1;
            tick();
            CLR = 1'b0;
            repeat (vecs[v].n_rise) pulse(vecs[v].ch);
            do_read(vecs[v].idx, vecs[v].hold, d, e);
            check($sformatf("vec%0d_data", v),
                  64'(d), 64'(vecs[v].exp_data));
            check($sformatf("vec%0d_err", v),
                  64'(e), 64'(vecs[v].exp_err));
            check($sformatf("vec%0d_ovf", v),
                  64'(OVF), 64'(vecs[v].exp_ovf));
        end

        // CLR wins over a same-edge rise, and clears OVF.
        CLR = 1'b1;
        tick();
        CLR = 1'b0;
        repeat (17) pulse(3);
        repeat (9) pulse(1);
        do_read(1, 0, d, e);
        check("pre_clr_cnt", 64'(d), 64'd9);
        EV[1] = 1'b1;
        CLR   = 1'b1;
        tick();
        CLR   = 1'b0;
        EV[1] = 1'b0;
        check("clr_ovf", 64'(OVF), 64'd0);
        do_read(1, 0, d, e);
        check("clr_rise_cnt", 64'(d), 64'd0);

        // A rise on the request edge is included in the capture.
        EV[2] = 1'b1;
        do_read(2, 0, d, e);
        check("same_edge_rise", 64'(d), 64'd1);
        EV[2] = 1'b0;
        tick();

        // Async reset while waiting for request release.
        repeat (3) pulse(0);
        RD_REQ = 1'b1;
        RD_IDX = 3'd0;
        tick();
        tick();
        check("in_wait_ack", 64'(RD_ACK), 64'd1);
        #2;
        RN = 1'b0;
        #1;
        check("async_rst_ack", 64'(RD_ACK), 64'd0);
        RD_REQ = 1'b0;
        tick();
        RN = 1'b1;
        tick();
        for (int i = 0; i < NCH; i++) begin
            do_read(i, 0, d, e);
            check($sformatf("post_rst_cnt%0d", i), 64'(d), 64'd0);
        end

        rand_ev = 1'b1;
        for (int k = 0; k < 60; k++) begin
            repeat ($urandom_range(1, 8)) tick();
            do_read($urandom_range(0, 7), $urandom_range(0, 3), d, e);
        end
        rand_ev = 1'b0;
        EV  = '0;
        CLR = 1'b0;
        tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
